// File: rtl/sparse_adder_pkg.sv
// sparse_adder_pkg: shared constants and helpers for the sparse-carry sum generator.
package sparse_adder_pkg;
    localparam int BLK_W = 4;

    function automatic int n_blocks(input int n_bit);
        return n_bit / BLK_W;
    endfunction
endpackage

// File: rtl/carry_select_block.sv
// carry_select_block: 4-bit carry-select sum slice, both carry-in cases precomputed.
module carry_select_block
    import sparse_adder_pkg::*;
(
    input  logic [BLK_W-1:0] a_i,
    input  logic [BLK_W-1:0] b_i,
    input  logic             cin_i,
    output logic [BLK_W-1:0] sum_o
);
    logic [BLK_W-1:0] sum0, sum1;

    assign sum0  = a_i + b_i;
    assign sum1  = a_i + b_i + BLK_W'(1);
    assign sum_o = cin_i ? sum1 : sum0;
endmodule

// File: rtl/sparse_tree_sum_pipeline.sv
// sparse_tree_sum_pipeline: two-stage elastic carry-select sum generator fed by
// the 4-sparse carries of a Sklansky carry tree.
module sparse_tree_sum_pipeline
    import sparse_adder_pkg::*;
#(
    parameter int N_BIT = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N_BIT-1:0]           operand_1,
    input  logic [N_BIT-1:0]           operand_2,
    input  logic                       carry_in,
    input  logic [n_blocks(N_BIT)-1:0] carries,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [N_BIT-1:0]           sum,
    output logic                       carry_out,
    output logic                       overflow
);
    localparam int NB = n_blocks(N_BIT);

    typedef struct packed {
        logic [N_BIT-1:0] sum;
        logic             carry_out;
        logic             overflow;
    } res_t;

    logic [N_BIT-1:0] a_q, b_q, sum_w;
    logic             cin_q;
    logic [NB-1:0]    c_q;
    logic             s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
    logic             s1_load, s2_load;
    logic [NB:0]      cin_v;
    res_t             res_d, res_q;

    // Block j takes the sparse carry into its low bit; the last one is the adder carry out.
    assign cin_v = {c_q, cin_q};

    for (genvar j = 0; j < NB; j++) begin : g_blk
        carry_select_block u_blk (
            .a_i   (a_q[j*BLK_W +: BLK_W]),
            .b_i   (b_q[j*BLK_W +: BLK_W]),
            .cin_i (cin_v[j]),
            .sum_o (sum_w[j*BLK_W +: BLK_W])
        );
    end

    assign res_d = '{
        sum:       sum_w,
        carry_out: cin_v[NB],
        overflow:  (a_q[N_BIT-1] == b_q[N_BIT-1]) && (sum_w[N_BIT-1] != a_q[N_BIT-1])
    };

    always_comb begin
        s2_load    = s1_valid_q && (!s2_valid_q || out_ready);
        in_ready   = !s1_valid_q || s2_load;
        s1_load    = in_valid && in_ready;
        s1_valid_d = s1_load || (s1_valid_q && !s2_load);
        s2_valid_d = s2_load || (s2_valid_q && !out_ready);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q        <= '0;
            b_q        <= '0;
            cin_q      <= 1'b0;
            c_q        <= '0;
            res_q      <= '0;
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
        end else begin
            if (s1_load) begin
                a_q   <= operand_1;
                b_q   <= operand_2;
                cin_q <= carry_in;
                c_q   <= carries;
            end
            if (s2_load) res_q <= res_d;
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign sum       = res_q.sum;
    assign carry_out = res_q.carry_out;
    assign overflow  = res_q.overflow;
endmodule

// File: tb/tb_sparse_tree_sum_pipeline.sv
// tb_sparse_tree_sum_pipeline: directed table, handshake corner cases and random
// traffic checked against an arithmetic A+B+cin reference with an ordered scoreboard.
module tb_sparse_tree_sum_pipeline;
    logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1, carry_in = 1'b0;
    logic [31:0] operand_1 = '0, operand_2 = '0, sum;
    logic [7:0]  carries = '0;
    logic        in_ready, out_valid, carry_out, overflow;

    int          tests = 0, fails = 0;
    logic [33:0] q[$];
    bit          mon_en = 1'b0, prev_stall = 1'b0;
    logic [33:0] prev_out = '0;

    typedef struct {
        logic [31:0] a, b;
        logic        cin;
        logic [31:0] s;
        logic        co, ov;
    } vec_t;
    vec_t tbl[6];

    sparse_tree_sum_pipeline #(.N_BIT(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .operand_1(operand_1), .operand_2(operand_2), .carry_in(carry_in), .carries(carries),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .carry_out(carry_out),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b, input logic cin);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b} + {32'd0, cin};
        return {s[31:0], s[32], (a[31] == b[31]) && (s[31] != a[31])};
    endfunction

    // Golden carry generator: carry into bit 4(j+1) from a masked low-part addition.
    function automatic logic [7:0] gen_carries(input logic [31:0] a, input logic [31:0] b, input logic cin);
        logic [7:0]  c;
        logic [32:0] m, lo;
        for (int j = 0; j < 8; j++) begin
            m    = (33'd1 << (4 * (j + 1))) - 33'd1;
            lo   = ({1'b0, a} & m) + ({1'b0, b} & m) + {32'd0, cin};
            c[j] = lo[4 * (j + 1)];
        end
        return c;
    endfunction

    function automatic logic [31:0] pick();
        int r;
        r = $urandom_range(0, 9);
        return r == 0 ? 32'hFFFF_FFFF : r == 1 ? 32'h7FFF_FFFF : r == 2 ? 32'h8000_0000 : $urandom;
    endfunction

    task automatic set_in(input logic [31:0] a, input logic [31:0] b, input logic cin);
        operand_1 = a;
        operand_2 = b;
        carry_in  = cin;
        carries   = gen_carries(a, b, cin);
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic cin);
        bit ok = 1'b0;
        set_in(a, b, cin);
        in_valid = 1'b1;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
        end
        chk("send_accept", {63'd0, ok}, 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 200 && q.size() != 0; t++) @(negedge clk);
        chk("drain_empty", 64'(q.size()), 64'd0);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (prev_stall) chk("stall_hold", {30'd0, out_valid, sum, carry_out, overflow}, {30'd0, 1'b1, prev_out});
            if (in_valid && in_ready) q.push_back(model(operand_1, operand_2, carry_in));
            if (out_valid && out_ready) begin
                if (q.size() == 0) chk("unexpected_out", {63'd0, out_valid}, 64'd0);
                else chk("result", {30'd0, sum, carry_out, overflow}, {30'd0, q.pop_front()});
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = {sum, carry_out, overflow};
        end
    end

    initial begin
        logic [33:0] e0;
        logic [13:0] pat;
        int          f;
        bit          xf;
        tbl[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        tbl[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        tbl[2] = '{32'h0000_000F, 32'h0000_0000, 1'b1, 32'h0000_0010, 1'b0, 1'b0};
        tbl[3] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
        tbl[4] = '{32'h1234_5678, 32'h1111_1111, 1'b1, 32'h2345_678A, 1'b0, 1'b0};
        tbl[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_sum", {32'd0, sum}, 64'd0);
        chk("rst_carry_out", {63'd0, carry_out}, 64'd0);
        chk("rst_overflow", {63'd0, overflow}, 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        mon_en = 1'b1;

        foreach (tbl[i]) begin
            @(posedge clk);
            #1 set_in(tbl[i].a, tbl[i].b, tbl[i].cin);
            in_valid = 1'b1;
            @(posedge clk);
            #1 in_valid = 1'b0;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("tbl%0d_valid", i), {63'd0, out_valid}, 64'd1);
            chk($sformatf("tbl%0d_sum", i), {32'd0, sum}, {32'd0, tbl[i].s});
            chk($sformatf("tbl%0d_co", i), {63'd0, carry_out}, {63'd0, tbl[i].co});
            chk($sformatf("tbl%0d_ov", i), {63'd0, overflow}, {63'd0, tbl[i].ov});
        end

        @(posedge clk);
        #1;
        fork
            for (int i = 0; i < 10; i++) send($urandom, $urandom, 1'($urandom));
            for (int i = 0; i < 14; i++) begin @(negedge clk); pat[i] = out_valid; end
        join
        f = 0;
        while (f < 13 && !pat[f]) f++;
        chk("b2b_contiguous", {50'd0, pat >> f}, 64'h3FF);

        @(posedge clk);
        #1 out_ready = 1'b0;
        e0 = model(32'hA5A5_A5A5, 32'h5A5A_5A5B, 1'b0);
        send(32'hA5A5_A5A5, 32'h5A5A_5A5B, 1'b0);
        send(32'h0000_FFFF, 32'h0000_0001, 1'b1);
        set_in(32'h8000_0001, 32'hFFFF_FFFF, 1'b0);
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
            chk("stall_out_valid", {63'd0, out_valid}, 64'd1);
            chk("stall_first_sum", {30'd0, sum, carry_out, overflow}, {30'd0, e0});
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        xf = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (in_ready) begin xf = 1'b1; break; end
        end
        chk("stall_release", {63'd0, xf}, 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        drain();

        @(posedge clk);
        #1 out_ready = 1'b0;
        send($urandom, $urandom, 1'b1);
        send($urandom, $urandom, 1'b0);
        mon_en = 1'b0;
        rst_n  = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        q.delete();
        prev_stall = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
        chk("mid_rst_sum", {32'd0, sum}, 64'd0);
        chk("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("no_stale", {63'd0, out_valid}, 64'd0);
        end
        mon_en = 1'b1;

        @(posedge clk);
        #1;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            xf = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (!in_valid || xf) begin
                in_valid = $urandom_range(0, 3) != 0;
                set_in(pick(), pick(), 1'($urandom));
            end
            out_ready = $urandom_range(0, 3) != 0;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
